bus_mux_reg: RTL and testbench

BUS_MUX_REG -- requirements
Module: bus_mux_reg

---
 rtl/bus_mux_reg.sv | 101 ++++++++++
 tb/tb_bus_mux_reg.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mux_reg.sv
// Registered N-source bus multiplexer with highest-index priority select,
// multi-driver conflict detection, sticky error flag and saturating conflict counter.
module bus_mux_reg #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NSRC      = 16,
  parameter int unsigned HOLD_LAST = 1,
  parameter int unsigned IDXW      = $clog2(NSRC)
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic [NSRC*WIDTH-1:0]   bus_in,
  input  logic [NSRC-1:0]         src_out,
  input  logic                    stall,
  input  logic                    err_clr,
  output logic [WIDTH-1:0]        bus_out,
  output logic                    bus_valid,
  output logic [IDXW-1:0]         sel_idx,
  output logic                    conflict,
  output logic                    conflict_err,
  output logic [7:0]              conflict_cnt
);

  localparam int unsigned CNTW    = 8;
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  logic [WIDTH-1:0] r_bus;
  logic             r_valid;
  logic [IDXW-1:0]  r_sel;
  logic             r_conflict;
  logic             r_err;
  logic [CNTW-1:0]  r_cnt;

  logic [IDXW-1:0]  w_sel_idx;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_any;
  logic             w_multi;

  // Ascending scan: the last requester seen is the highest index and wins;
  // a request seen after another one marks a multi-driver cycle.
  always_comb begin
    w_sel_idx  = '0;
    w_sel_data = '0;
    w_any      = 1'b0;
    w_multi    = 1'b0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (src_out[i]) begin
        w_multi    = w_multi | w_any;
        w_any      = 1'b1;
        w_sel_idx  = IDXW'(i);
        w_sel_data = bus_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output registers; err_clr is applied last so it beats a same-edge conflict
  // and still works while stalled.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_bus      <= '0;
      r_valid    <= 1'b0;
      r_sel      <= '0;
      r_conflict <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (!stall) begin
        r_conflict <= w_multi;
        if (w_any) begin
          r_bus   <= w_sel_data;
          r_sel   <= w_sel_idx;
          r_valid <= 1'b1;
        end else begin
          r_valid <= 1'b0;
          if (HOLD_LAST == 0) begin
            r_bus <= '0;
          end
        end
        if (w_multi) begin
          r_err <= 1'b1;
          if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
      end else begin
        r_conflict <= 1'b0;
      end
      if (err_clr) begin
        r_err <= 1'b0;
        r_cnt <= '0;
      end
    end
  end

  assign bus_out      = r_bus;
  assign bus_valid    = r_valid;
  assign sel_idx      = r_sel;
  assign conflict     = r_conflict;
  assign conflict_err = r_err;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Scoreboard bench for bus_mux_reg: stimulus pushes model predictions,
// a monitor pops and compares after every clock edge. Two DUTs cover both HOLD_LAST modes.
module tb_bus_mux_reg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NSRC  = 16;
  localparam int unsigned IDXW  = 4;

  logic                  clock;
  logic                  clear;
  logic [NSRC*WIDTH-1:0] bus_in;
  logic [NSRC-1:0]       src_out;
  logic                  stall;
  logic                  err_clr;

  logic [WIDTH-1:0] bus_out_h, bus_out_z;
  logic             bus_valid_h, bus_valid_z;
  logic [IDXW-1:0]  sel_idx_h, sel_idx_z;
  logic             conflict_h, conflict_z;
  logic             conflict_err_h, conflict_err_z;
  logic [7:0]       conflict_cnt_h, conflict_cnt_z;

  bus_mux_reg #(.WIDTH(WIDTH), .NSRC(NSRC), .HOLD_LAST(1), .IDXW(IDXW)) dut_h (
    .clock(clock), .clear(clear), .bus_in(bus_in), .src_out(src_out),
    .stall(stall), .err_clr(err_clr), .bus_out(bus_out_h), .bus_valid(bus_valid_h),
    .sel_idx(sel_idx_h), .conflict(conflict_h), .conflict_err(conflict_err_h),
    .conflict_cnt(conflict_cnt_h)
  );

  bus_mux_reg #(.WIDTH(WIDTH), .NSRC(NSRC), .HOLD_LAST(0), .IDXW(IDXW)) dut_z (
    .clock(clock), .clear(clear), .bus_in(bus_in), .src_out(src_out),
    .stall(stall), .err_clr(err_clr), .bus_out(bus_out_z), .bus_valid(bus_valid_z),
    .sel_idx(sel_idx_z), .conflict(conflict_z), .conflict_err(conflict_err_z),
    .conflict_cnt(conflict_cnt_z)
  );

  typedef struct {
    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] bus_z;
    logic             valid;
    logic [IDXW-1:0]  sel;
    logic             conf;
    logic             err;
    logic [7:0]       cnt;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state
  logic [WIDTH-1:0] m_bus, m_bus_z;
  logic             m_valid, m_conf, m_err;
  logic [IDXW-1:0]  m_sel;
  int               m_cnt;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.bus   = m_bus;
    e.bus_z = m_bus_z;
    e.valid = m_valid;
    e.sel   = m_sel;
    e.conf  = m_conf;
    e.err   = m_err;
    e.cnt   = 8'(m_cnt);
    return e;
  endfunction

  function automatic logic [NSRC*WIDTH-1:0] rand_data();
    logic [NSRC*WIDTH-1:0] d;
    for (int i = 0; i < int'(NSRC); i++) d[i*WIDTH +: WIDTH] = $urandom;
    return d;
  endfunction

  function automatic logic [NSRC-1:0] rand_src();
    int mode;
    mode = $urandom_range(0, 3);
    if (mode == 0) return '0;
    if (mode == 1) return NSRC'(1) << $urandom_range(0, NSRC - 1);
    return NSRC'($urandom);
  endfunction

  // One clock of stimulus with clear high; the model predicts the state after the next edge.
  task automatic step(input logic [NSRC-1:0] src, input logic st, input logic ec,
                      input logic [NSRC*WIDTH-1:0] data);
    int n;
    int hi;
    @(negedge clock);
    clear   = 1'b1;
    src_out = src;
    stall   = st;
    err_clr = ec;
    bus_in  = data;
    n  = $countones(src);
    m_conf = 1'b0;
    if (!st) begin
      if (n > 0) begin
        hi      = $clog2(32'(src) + 1) - 1;
        m_bus   = data[hi*WIDTH +: WIDTH];
        m_bus_z = m_bus;
        m_sel   = IDXW'(hi);
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
        m_bus_z = '0;
      end
      if (n >= 2) begin
        m_conf = 1'b1;
        m_err  = 1'b1;
        m_cnt  = (m_cnt >= 255) ? 255 : m_cnt + 1;
      end
    end
    if (ec) begin
      m_err = 1'b0;
      m_cnt = 0;
    end
    q.push_back(snap());
  endtask

  // Assert clear between edges and confirm every output drops without a clock edge.
  task automatic do_reset();
    @(negedge clock);
    clear   = 1'b0;
    stall   = 1'($urandom);
    err_clr = 1'($urandom);
    #1;
    chk("async_bus_out",  bus_out_h,            '0);
    chk("async_bus_z",    bus_out_z,            '0);
    chk("async_valid",    32'(bus_valid_h),     '0);
    chk("async_sel",      32'(sel_idx_h),       '0);
    chk("async_conflict", 32'(conflict_h),      '0);
    chk("async_err",      32'(conflict_err_h),  '0);
    chk("async_cnt",      32'(conflict_cnt_h),  '0);
    m_bus = '0; m_bus_z = '0; m_valid = 1'b0; m_sel = '0;
    m_conf = 1'b0; m_err = 1'b0; m_cnt = 0;
    q.push_back(snap());
  endtask

  // Monitor: every edge with a pending prediction is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("bus_out",      bus_out_h,            e.bus);
        chk("bus_out_hl0",  bus_out_z,            e.bus_z);
        chk("bus_valid",    32'(bus_valid_h),     32'(e.valid));
        chk("bus_valid_hl0",32'(bus_valid_z),     32'(e.valid));
        chk("sel_idx",      32'(sel_idx_h),       32'(e.sel));
        chk("conflict",     32'(conflict_h),      32'(e.conf));
        chk("conflict_err", 32'(conflict_err_h),  32'(e.err));
        chk("conflict_cnt", 32'(conflict_cnt_h),  32'(e.cnt));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NSRC*WIDTH-1:0] d;
    clear   = 1'b0;
    stall   = 1'b0;
    err_clr = 1'b0;
    src_out = '0;
    bus_in  = '0;
    do_reset();

    // Single requester, then idle hold / zero behaviour
    d = rand_data();
    d[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
    step(16'h0004, 1'b0, 1'b0, d);
    step(16'h0000, 1'b0, 1'b0, rand_data());

    // Two requesters: highest index wins and a conflict is raised
    d = rand_data();
    d[0 +: WIDTH]        = 32'h11;
    d[15*WIDTH +: WIDTH] = 32'hFF;
    step(16'h8001, 1'b0, 1'b0, d);

    // Stall freezes everything and masks the conflict pulse
    repeat (3) step(16'h0003, 1'b1, 1'b0, rand_data());
    step(16'h0003, 1'b1, 1'b1, rand_data());

    // Counter saturation, then err_clr against a same-edge conflict
    repeat (300) step(NSRC'($urandom) | 16'h0101, 1'b0, 1'b0, rand_data());
    step(16'hC000, 1'b0, 1'b1, rand_data());

    repeat (400) step(rand_src(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), rand_data());

    // Mid-operation reset while the bus is valid
    step(16'h0010, 1'b0, 1'b0, rand_data());
    do_reset();
    step(16'h0020, 1'b0, 1'b0, rand_data());

    repeat (200) step(rand_src(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), rand_data());

    repeat (2) @(negedge clock);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
